// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and primary opcode encodings.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDIU = 6'h09,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selections and the hazard-tracking FSM state encoding.
package data_path_muxs_pkg;

  typedef enum logic [1:0] {
    RT_DEST = 2'd0,
    RD_DEST = 2'd1,
    RA_DEST = 2'd2
  } reg_dest_mux_selection;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/forward_unit_if.sv
// Forwarding-unit bundle; the dtu modport is the destination-tracking producer side.
interface forward_unit_if;
  import cpu_types_pkg::*;

  regbits_t reg_wr_mem;
  regbits_t reg_wr_wb;
  opcode_t  opcode_ID_EX;

  modport dtu (output reg_wr_mem, output reg_wr_wb, output opcode_ID_EX);
  modport fu  (input  reg_wr_mem, input  reg_wr_wb, input  opcode_ID_EX);

endinterface

// File: rtl/dest_stage_reg.sv
// One pipeline stage of destination/opcode tracking; bubble loads a NOP.
module dest_stage_reg
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     en,
  input  logic     bubble,
  input  regbits_t d_reg,
  input  opcode_t  d_op,
  output regbits_t q_reg,
  output opcode_t  q_op
);

  // Stage register: hold unless enabled, NOP on bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg <= 5'd0;
      q_op  <= RTYPE;
    end else if (en) begin
      if (bubble) begin
        q_reg <= 5'd0;
        q_op  <= RTYPE;
      end else begin
        q_reg <= d_reg;
        q_op  <= d_op;
      end
    end
  end

endmodule

// File: rtl/dest_track_unit.sv
// Tracks in-flight destination registers through EX/MEM/WB and issues
// load-use / memory-wait stall and bubble controls.
module dest_track_unit
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  logic                  dmem_req,
  input  logic                  dhit,
  input  logic                  flush,
  input  opcode_t               id_opcode,
  input  regbits_t              id_rs,
  input  regbits_t              id_rt,
  input  regbits_t              id_rd,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_wen,
  input  reg_dest_mux_selection id_reg_dest,
  output regbits_t              reg_wr_ex,
  output regbits_t              reg_wr_mem,
  output regbits_t              reg_wr_wb,
  output opcode_t               opcode_ex,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output hazard_state_t         hz_state,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  regbits_t      id_dest_s;
  logic          adv_s;
  logic          lu_s;
  logic          mem_wait_s;
  regbits_t      ex_reg_s, mem_reg_s, wb_reg_s;
  opcode_t       ex_op_s, mem_op_s, wb_op_s;
  logic          unused_op_s;
  hazard_state_t state_r, next_state_s;
  logic [CNT_W-1:0] count_r;

  forward_unit_if fu_if ();

  // Destination select; a non-writing instruction tracks as register 0.
  always_comb begin
    id_dest_s = 5'd0;
    if (id_reg_wen) begin
      case (id_reg_dest)
        RT_DEST: id_dest_s = id_rt;
        RD_DEST: id_dest_s = id_rd;
        RA_DEST: id_dest_s = 5'd31;
        default: id_dest_s = 5'd0;
      endcase
    end else begin
      id_dest_s = 5'd0;
    end
  end

  assign mem_wait_s = dmem_req & ~dhit;
  assign adv_s      = ihit & ~mem_wait_s;
  assign lu_s       = (ex_op_s == LW) && (ex_reg_s != 5'd0) &&
                      ((ex_reg_s == id_rs) || (id_uses_rt && (ex_reg_s == id_rt)));

  // A flushed ID instruction is squashed anyway, so it must not also stall.
  assign bubble_id_ex = flush | lu_s;
  assign stall_if_id  = (lu_s & ~flush) | ~adv_s;

  dest_stage_reg u_ex (
    .CLK(CLK), .RST(RST), .en(adv_s), .bubble(bubble_id_ex),
    .d_reg(id_dest_s), .d_op(id_opcode), .q_reg(ex_reg_s), .q_op(ex_op_s)
  );

  dest_stage_reg u_mem (
    .CLK(CLK), .RST(RST), .en(adv_s), .bubble(1'b0),
    .d_reg(ex_reg_s), .d_op(ex_op_s), .q_reg(mem_reg_s), .q_op(mem_op_s)
  );

  dest_stage_reg u_wb (
    .CLK(CLK), .RST(RST), .en(adv_s), .bubble(1'b0),
    .d_reg(mem_reg_s), .d_op(mem_op_s), .q_reg(wb_reg_s), .q_op(wb_op_s)
  );

  assign unused_op_s = ^wb_op_s;

  assign fu_if.reg_wr_mem   = mem_reg_s;
  assign fu_if.reg_wr_wb    = wb_reg_s;
  assign fu_if.opcode_ID_EX = ex_op_s;

  assign reg_wr_ex  = ex_reg_s;
  assign reg_wr_mem = fu_if.reg_wr_mem;
  assign reg_wr_wb  = fu_if.reg_wr_wb;
  assign opcode_ex  = fu_if.opcode_ID_EX;

  // Hazard FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Hazard FSM next state; a memory wait overrides a pending load-use bubble.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (mem_wait_s) begin
          next_state_s = MEM_WAIT;
        end else if (adv_s && lu_s && !flush) begin
          next_state_s = LU_BUBBLE;
        end else begin
          next_state_s = RUN;
        end
      end
      LU_BUBBLE: begin
        if (mem_wait_s) begin
          next_state_s = MEM_WAIT;
        end else if (adv_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = LU_BUBBLE;
        end
      end
      MEM_WAIT: begin
        if (dhit) begin
          next_state_s = RUN;
        end else begin
          next_state_s = MEM_WAIT;
        end
      end
      default: next_state_s = RUN;
    endcase
  end

  assign hz_state = state_r;

  // Lost-cycle counter; every stall cycle is a lost cycle, saturating.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else if (stall_if_id && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign stall_count = count_r;

endmodule

// File: tb/tb_dest_track_unit.sv
// Scoreboard bench for dest_track_unit: a reference model pushes expected
// stage contents per driven cycle; they are popped after the clock edge.
module tb_dest_track_unit;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b1, dmem_req = 1'b0, dhit = 1'b0, flush = 1'b0;
  opcode_t id_opcode = RTYPE;
  regbits_t id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic id_uses_rt = 1'b0, id_reg_wen = 1'b0;
  reg_dest_mux_selection id_reg_dest = RD_DEST;
  regbits_t reg_wr_ex, reg_wr_mem, reg_wr_wb;
  opcode_t opcode_ex;
  logic stall_if_id, bubble_id_ex;
  hazard_state_t hz_state;
  logic [CW-1:0] stall_count;

  dest_track_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .flush(flush), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_reg_wen(id_reg_wen),
    .id_reg_dest(id_reg_dest), .reg_wr_ex(reg_wr_ex), .reg_wr_mem(reg_wr_mem),
    .reg_wr_wb(reg_wr_wb), .opcode_ex(opcode_ex), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .hz_state(hz_state), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ex, mem, wb, op, st, cnt;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int m_ex, m_mem, m_wb, m_cnt;
  opcode_t m_op;
  hazard_state_t m_st;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = 0; m_mem = 0; m_wb = 0; m_cnt = 0; m_op = RTYPE; m_st = RUN;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    chk({tag, ".st"},  int'(hz_state), int'(RUN));
    chk({tag, ".ex"},  int'(reg_wr_ex), 0);
    chk({tag, ".mem"}, int'(reg_wr_mem), 0);
    chk({tag, ".wb"},  int'(reg_wr_wb), 0);
    chk({tag, ".op"},  int'(opcode_ex), int'(RTYPE));
    chk({tag, ".cnt"}, int'(stall_count), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic set_id(input opcode_t op, input int rs, input int rt, input int rd,
                        input logic urt, input logic wen, input reg_dest_mux_selection ds);
    id_opcode = op; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_uses_rt = urt; id_reg_wen = wen; id_reg_dest = ds;
  endtask

  task automatic step(input string tag);
    int idd;
    logic adv, lu, bub, stl;
    exp_t e;
    #1;
    if (!id_reg_wen) idd = 0;
    else if (id_reg_dest == RT_DEST) idd = int'(id_rt);
    else if (id_reg_dest == RD_DEST) idd = int'(id_rd);
    else idd = 31;
    adv = ihit && !(dmem_req && !dhit);
    lu  = (m_op == LW) && (m_ex != 0) &&
          ((m_ex == int'(id_rs)) || (id_uses_rt && (m_ex == int'(id_rt))));
    bub = flush || lu;
    stl = (lu && !flush) || !adv;
    chk({tag, ".stall"}, int'(stall_if_id), int'(stl));
    chk({tag, ".bubble"}, int'(bubble_id_ex), int'(bub));
    case (m_st)
      RUN:       if (dmem_req && !dhit) m_st = MEM_WAIT;
                 else if (adv && lu && !flush) m_st = LU_BUBBLE;
      LU_BUBBLE: if (dmem_req && !dhit) m_st = MEM_WAIT;
                 else if (adv) m_st = RUN;
      MEM_WAIT:  if (dhit) m_st = RUN;
      default:   m_st = RUN;
    endcase
    if (stl && m_cnt < CMAX) m_cnt++;
    if (adv) begin
      m_wb = m_mem; m_mem = m_ex;
      m_ex = bub ? 0 : idd;
      m_op = bub ? RTYPE : id_opcode;
    end
    e.ex = m_ex; e.mem = m_mem; e.wb = m_wb; e.op = int'(m_op);
    e.st = int'(m_st); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ex"},  int'(reg_wr_ex), e.ex);
      chk({tag, ".mem"}, int'(reg_wr_mem), e.mem);
      chk({tag, ".wb"},  int'(reg_wr_wb), e.wb);
      chk({tag, ".op"},  int'(opcode_ex), e.op);
      chk({tag, ".st"},  int'(hz_state), e.st);
      chk({tag, ".cnt"}, int'(stall_count), e.cnt);
    end
  endtask

  task automatic nop();
    set_id(RTYPE, 0, 0, 0, 1'b0, 1'b0, RD_DEST);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #3;
    chk("rst0.st", int'(hz_state), int'(RUN));
    chk("rst0.ex", int'(reg_wr_ex), 0);
    chk("rst0.op", int'(opcode_ex), int'(RTYPE));
    chk("rst0.cnt", int'(stall_count), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Shift: ADDU rd=5, then JAL.
    set_id(RTYPE, 1, 2, 5, 1'b1, 1'b1, RD_DEST);
    step("sh1"); chk("sh1.ex5", int'(reg_wr_ex), 5);
    nop(); step("sh2"); chk("sh2.mem5", int'(reg_wr_mem), 5);
    step("sh3"); chk("sh3.wb5", int'(reg_wr_wb), 5);
    set_id(JAL, 0, 0, 0, 1'b0, 1'b1, RA_DEST);
    step("jal1"); chk("jal1.ex31", int'(reg_wr_ex), 31);
    nop(); step("jal2"); step("jal3"); chk("jal3.wb31", int'(reg_wr_wb), 31);

    // Load-use: LW rt=8 then ADDU rs=8 (held), then a second dependent.
    do_reset("rstlu");
    set_id(LW, 2, 8, 0, 1'b0, 1'b1, RT_DEST);
    step("lw");
    set_id(RTYPE, 8, 3, 9, 1'b1, 1'b1, RD_DEST);
    step("lu1");
    chk("lu1.ex0", int'(reg_wr_ex), 0);
    chk("lu1.mem8", int'(reg_wr_mem), 8);
    chk("lu1.cnt1", int'(stall_count), 1);
    step("lu2");
    chk("lu2.ex9", int'(reg_wr_ex), 9);
    chk("lu2.wb8", int'(reg_wr_wb), 8);
    set_id(RTYPE, 8, 8, 10, 1'b1, 1'b1, RD_DEST);
    step("lu3"); chk("lu3.nostall_ex10", int'(reg_wr_ex), 10);

    // No false hazard: LW to $0, and rt match with id_uses_rt low.
    set_id(LW, 2, 0, 0, 1'b0, 1'b1, RT_DEST); step("lw0");
    set_id(RTYPE, 0, 0, 4, 1'b1, 1'b1, RD_DEST); step("nf1");
    set_id(LW, 2, 8, 0, 1'b0, 1'b1, RT_DEST); step("lw8");
    set_id(RTYPE, 1, 8, 4, 1'b0, 1'b1, RD_DEST); step("nf2");

    // Flush together with load-use: bubble only.
    set_id(LW, 2, 8, 0, 1'b0, 1'b1, RT_DEST); step("lwf");
    set_id(RTYPE, 8, 3, 9, 1'b1, 1'b1, RD_DEST); flush = 1'b1;
    step("flu"); chk("flu.st_run", int'(hz_state), int'(RUN));
    flush = 1'b0; nop(); step("flu2");

    // Memory wait of 4 cycles, flush raised while stalled.
    do_reset("rstmw");
    set_id(RTYPE, 1, 2, 5, 1'b1, 1'b1, RD_DEST); step("mw_a");
    set_id(RTYPE, 1, 2, 6, 1'b1, 1'b1, RD_DEST); step("mw_b");
    dmem_req = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) flush = 1'b1;
      step("mw");
    end
    chk("mw.hold_ex", int'(reg_wr_ex), 6);
    chk("mw.hold_mem", int'(reg_wr_mem), 5);
    chk("mw.cnt4", int'(stall_count), 4);
    chk("mw.state", int'(hz_state), int'(MEM_WAIT));
    dhit = 1'b1; step("mw_hit");
    chk("mw_hit.run", int'(hz_state), int'(RUN));
    chk("mw_hit.flushed", int'(reg_wr_ex), 0);
    flush = 1'b0; dmem_req = 1'b0; dhit = 1'b0; nop();

    // Random traffic through the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: id_opcode = LW;
        1: id_opcode = ADDIU;
        2: id_opcode = JAL;
        3: id_opcode = SW;
        default: id_opcode = RTYPE;
      endcase
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_reg_wen  = 1'($urandom_range(0, 1));
      id_reg_dest = reg_dest_mux_selection'($urandom_range(0, 2));
      ihit     = ($urandom_range(0, 3) != 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dhit     = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    // Saturation, then asynchronous reset from MEM_WAIT.
    do_reset("rstsat");
    ihit = 1'b1; flush = 1'b0; nop();
    dmem_req = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.cnt15", int'(stall_count), 15);
    do_reset("rstmid");
    dmem_req = 1'b0;
    step("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dest_track_unit.md
# dest_track_unit

Tracks the destination register of every in-flight instruction through the EX, MEM and WB stages of the five-stage pipeline. It drives the forwarding unit's `reg_wr_mem`, `reg_wr_wb` and `opcode_ID_EX` inputs, so it is the producer side of that interface. It also detects load-use hazards and data-memory waits, and issues the stall and bubble controls to the pipeline latches.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `CLK`, input, 1: system clock, rising edge.
- `RST`, input, 1: reset, asynchronous, active-high.
- `ihit`, input, 1: instruction fetch complete this cycle.
- `dmem_req`, input, 1: instruction in MEM is a load or store.
- `dhit`, input, 1: data access complete this cycle.
- `flush`, input, 1: taken branch or jump resolved; squash the ID instruction.
- `id_opcode`, input, `opcode_t`: opcode in IF/ID.
- `id_rs`, `id_rt`, `id_rd`, input, `regbits_t`: register fields in IF/ID.
- `id_uses_rt`, input, 1: the ID instruction reads rt as a source.
- `id_reg_wen`, input, 1: the ID instruction writes the register file.
- `id_reg_dest`, input, `reg_dest_mux_selection`: destination select (rt, rd, $31).
- `reg_wr_ex`, `reg_wr_mem`, `reg_wr_wb`, output, `regbits_t`: destination per stage; 0 means no write.
- `opcode_ex`, output, `opcode_t`: opcode in ID/EX; this drives `opcode_ID_EX`.
- `stall_if_id`, output, 1: hold the PC and IF/ID.
- `bubble_id_ex`, output, 1: load a NOP into ID/EX on this advance.
- `hz_state`, output, `hazard_state_t`: current FSM state.
- `stall_count`, output, `CNT_W`: saturating count of lost cycles.

## Operation
- Destination resolve: `id_dest` is `id_rt`, `id_rd` or 5'd31 according to `id_reg_dest`. It is forced to 0 when `id_reg_wen` is low.
- Advance: `adv = ihit & ~(dmem_req & ~dhit)`. When `adv` is low, all stage registers hold.
- Load-use condition: `lu = (opcode_ex == LW) & (reg_wr_ex != 0) & ((reg_wr_ex == id_rs) | (id_uses_rt & reg_wr_ex == id_rt))`.
- On `adv`, the stages shift:
  - `reg_wr_wb` takes `reg_wr_mem`.
  - `reg_wr_mem` takes `reg_wr_ex`.
  - `reg_wr_ex` and `opcode_ex` take `id_dest` and `id_opcode`, unless `bubble_id_ex` is set. In that case they load 0 and RTYPE (a NOP).
- `bubble_id_ex = flush | lu`, combinational.
- `stall_if_id = (lu & ~flush) | ~adv`, combinational. Flush has priority over load-use: the squashed instruction must not stall.
- $0 is never tracked as a destination; writes to $0 are encoded as 0.
- FSM, `hazard_state_t` with states RUN, LU_BUBBLE and MEM_WAIT:
  - RUN → MEM_WAIT when `dmem_req & ~dhit`.
  - RUN → LU_BUBBLE when `adv & lu & ~flush`.
  - LU_BUBBLE → RUN on the next `adv`, or → MEM_WAIT if `dmem_req & ~dhit` first.
  - MEM_WAIT → RUN on `dhit`.
- `stall_count` increments by 1 every cycle that `adv` is low or a load-use bubble is inserted. It saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous, any cycle, including mid-stall):
  - `reg_wr_ex`, `reg_wr_mem`, `reg_wr_wb` and `stall_count` go to 0.
  - `opcode_ex` goes to RTYPE.
  - `hz_state` goes to RUN.
  - `stall_if_id` and `bubble_id_ex` then follow the combinational equations.
- Stage registers update one edge after `adv`, so each stage is one cycle behind the previous.
- A load-use hazard costs exactly one bubble:
  - Edge n: LW in EX, dependent instruction in ID, stall.
  - Edge n+1: bubble in EX.
  - Edge n+2: dependent instruction in EX, LW in WB, forwarded from WB.
- `flush` together with `lu`: one bubble, no stall.
- `flush` with `adv` low: no effect until `adv`. The upstream holds `flush` until the advance.
- Back-to-back LW → dependent → dependent: only the first dependent instruction stalls.

## Structure
- Add `hazard_state_t` (2-bit enum: RUN, LU_BUBBLE, MEM_WAIT) to `data_path_muxs_pkg`.
- `opcode_t`, `regbits_t` and LW/RTYPE come from `cpu_types_pkg`.
- Sub-module `dest_stage_reg`: a one-stage register for `regbits_t` and `opcode_t` with `en` and `bubble` inputs, instantiated for EX, MEM and WB.
- Extend `forward_unit_if` with a companion modport `dtu` that outputs `reg_wr_mem`, `reg_wr_wb` and `opcode_ID_EX`.

## Test plan
- Reset mid-MEM_WAIT:
  - Stimulus: `dmem_req=1`, `dhit=0` for 3 cycles, then `RST` pulse.
  - Required: `hz_state=RUN`, all `reg_wr_*=0`, `stall_count=0` immediately, without waiting for a clock edge.
- Shift:
  - Stimulus: `ihit=1` every cycle; ID issues ADDU with `rd=5`, `wen`, `id_reg_dest=rd`.
  - Required: `reg_wr_ex=5`, then `reg_wr_mem=5`, then `reg_wr_wb=5` on consecutive edges.
  - Stimulus: ID issues JAL.
  - Required: 31 propagates through the stages.
- Load-use:
  - Stimulus: LW with `rt=8` in EX; ID has ADDU with `rs=8`.
  - Required: `stall_if_id=1` and `bubble_id_ex=1` for 1 cycle; next edge `reg_wr_ex=0`, `reg_wr_mem=8`; `stall_count=1`.
- No false hazard:
  - Stimulus: LW to $0, or ID reading rt=8 with `id_uses_rt=0`.
  - Required: no stall.
- Flush with load-use simultaneous:
  - Required: `bubble_id_ex=1`, `stall_if_id=0`, state stays RUN.
- Memory wait:
  - Stimulus: `dhit` low for 4 cycles.
  - Required: all stage registers hold, `stall_count` rises by 4, MEM_WAIT → RUN on `dhit`.
- Saturation:
  - Stimulus: `CNT_W=4`, 20 wait cycles.
  - Required: `stall_count=15`.
